serial_slave_port: RTL and testbench

Slave-side endpoint of the serial system bus. It deserialises a frame (mode, address, optional write data) arriving bit-serially from the address decoder, then performs one parallel access on a local memory interface. For reads it serialises the returned word back to the bus. It sits between the decoder's per-slave mvalid line and a BRAM or register bank, so any slave memory can be bus-attached without its own bit-level logic.

---
 rtl/serial_bus_pkg.sv | 31 +++
 rtl/serial_shift_reg.sv | 40 ++++
 rtl/serial_slave_port.sv | 224 ++++++++++++++++++++++
 tb/tb_serial_slave_port.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// Shared types and defaults for the serial system bus slave endpoint.
// Holds the FSM state encoding, frame mode values and shift-register opcodes.
package serial_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_MEMWR,
        ST_MEMRD,
        ST_RWAIT,
        ST_RDATA
    } ssp_state_e;

    typedef enum logic [1:0] {
        SR_HOLD,
        SR_LOAD,
        SR_SHIFT
    } sr_op_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first shift register: parallel load, serial-in at the MSB end, serial-out at bit 0.
// The same right-shift serves both deserialising (SIPO) and serialising (PISO).
module serial_shift_reg
    import serial_bus_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  sr_op_e           op,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sin,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        // NOTE: default assignment first, so no path through the block leaves data_d unassigned (no latch).
        data_d = data_q;
        case (op)
            SR_LOAD:  data_d = load_data;
            SR_SHIFT: data_d = {sin, data_q[WIDTH-1:1]};
            default:  data_d = data_q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/serial_slave_port.sv
// Serial bus slave endpoint: deserialises mode/address/write-data, does one memory access,
// serialises read data back. Optional idle-gap abort is enabled with `define SSP_TIMEOUT_EN.
module serial_slave_port
    import serial_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  frame_err
);

    localparam int CNT_MAX = max_int(max_int(ADDR_WIDTH, DATA_WIDTH),
                                     max_int(TIMEOUT_CYCLES, READ_LATENCY));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    ssp_state_e            state_q, state_d;
    cnt_t                  cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    sr_op_e                addr_op, wd_op, rd_op;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [DATA_WIDTH-1:0] wdata_sr;
    logic [DATA_WIDTH-1:0] rd_sr;
    logic                  rd_unused;
    logic                  timeout_hit;

    serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
        .clk       (clk),
        .rst       (rst),
        .op        (addr_op),
        .load_data ('0),
        .sin       (swdata),
        .data      (addr_sr)
    );

    serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_wdata_sr (
        .clk       (clk),
        .rst       (rst),
        .op        (wd_op),
        .load_data ('0),
        .sin       (swdata),
        .data      (wdata_sr)
    );

    serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rdata_sr (
        .clk       (clk),
        .rst       (rst),
        .op        (rd_op),
        .load_data (mem_rdata),
        .sin       (1'b0),
        .data      (rd_sr)
    );

    // Only bit 0 of the read register drives the bus; upper bits just feed the shift.
    assign rd_unused = ^rd_sr[DATA_WIDTH-1:1];

`ifdef SSP_TIMEOUT_EN
    cnt_t gap_q, gap_d;
    logic frame_err_q;

    always_comb begin
        gap_d       = '0;
        timeout_hit = 1'b0;
        if ((state_q == ST_ADDR || state_q == ST_WDATA) && !mvalid) begin
            if (gap_q == cnt_t'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                gap_d = gap_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            gap_q       <= gap_d;
            frame_err_q <= timeout_hit;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign timeout_hit = 1'b0;
    assign frame_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mode_q     <= MODE_READ;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        mem_addr_d = mem_addr_q;
        addr_op    = SR_HOLD;
        wd_op      = SR_HOLD;
        rd_op      = SR_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (mvalid) begin
                    mode_d  = smode;
                    addr_op = SR_SHIFT;
                    cnt_d   = cnt_t'(1);
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (mvalid) begin
                    addr_op = SR_SHIFT;
                    if (cnt_q == cnt_t'(ADDR_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = (mode_q == MODE_WRITE) ? ST_WDATA : ST_MEMRD;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            ST_WDATA: begin
                if (mvalid) begin
                    wd_op = SR_SHIFT;
                    if (cnt_q == cnt_t'(DATA_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_MEMWR;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            ST_MEMWR: begin
                mem_addr_d = addr_sr;
                state_d    = ST_IDLE;
            end
            ST_MEMRD: begin
                mem_addr_d = addr_sr;
                state_d    = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (cnt_q == cnt_t'(READ_LATENCY - 1)) begin
                    rd_op   = SR_LOAD;
                    cnt_d   = '0;
                    state_d = ST_RDATA;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            ST_RDATA: begin
                rd_op = SR_SHIFT;
                if (cnt_q == cnt_t'(DATA_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A stalled frame is dropped without touching memory.
        if (timeout_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            addr_op = SR_HOLD;
            wd_op   = SR_HOLD;
        end
    end

    always_comb begin
        sready   = 1'b0;
        svalid   = 1'b0;
        srdata   = 1'b0;
        mem_wen  = 1'b0;
        mem_ren  = 1'b0;
        mem_addr = mem_addr_q;
        case (state_q)
            ST_IDLE:  sready = 1'b1;
            ST_MEMWR: begin
                mem_wen  = 1'b1;
                mem_addr = addr_sr;
            end
            ST_MEMRD: begin
                mem_ren  = 1'b1;
                mem_addr = addr_sr;
            end
            ST_RDATA: begin
                svalid = 1'b1;
                srdata = rd_sr[0];
            end
            default: ;
        endcase
    end

    assign mem_wdata = wdata_sr;

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port: table of whole frames plus hand sequences for
// reset mid-frame, back-to-back access and the idle-gap behaviour (SSP_TIMEOUT_EN aware).
module tb_serial_slave_port;
    import serial_bus_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          swdata = 1'b0;
    logic          smode = 1'b0;
    logic          mvalid = 1'b0;
    logic          srdata, svalid, sready, mem_wen, mem_ren, frame_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    serial_slave_port #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .READ_LATENCY   (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .swdata    (swdata),
        .smode     (smode),
        .mvalid    (mvalid),
        .srdata    (srdata),
        .svalid    (svalid),
        .sready    (sready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata),
        .frame_err (frame_err)
    );

    // Single-cycle-latency memory model behind the slave.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observers sample on the falling edge, away from the active edge.
    int            wen_n = 0, ren_n = 0, ov_n = 0, sv_n = 0, fe_n = 0;
    int            wen_cyc = 0, ren_cyc = 0, sv_first = 0, fall_cyc = 0, rise_cyc = 0, fe_cyc = 0;
    logic [AW-1:0] wen_addr = '0, ren_addr = '0;
    logic [DW-1:0] wen_data = '0, rd_word = '0;
    logic          sready_prev = 1'b1;

    always @(negedge clk) begin
        if (mem_wen) begin
            wen_n++; wen_cyc = cyc; wen_addr = mem_addr; wen_data = mem_wdata;
        end
        if (mem_ren) begin
            ren_n++; ren_cyc = cyc; ren_addr = mem_addr;
        end
        if (mem_wen && mem_ren) ov_n++;
        if (svalid) begin
            if (sv_n == 0) sv_first = cyc;
            if (sv_n < DW) rd_word[sv_n] = srdata;
            sv_n++;
        end
        if (frame_err) begin
            fe_n++; fe_cyc = cyc;
        end
        if (sready_prev && !sready) fall_cyc = cyc;
        if (!sready_prev && sready) rise_cyc = cyc;
        sready_prev = sready;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mvalid = 1'b0;
        swdata = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_bit(input logic mode, input logic b);
        mvalid = 1'b1;
        smode  = mode;
        swdata = b;
        step();
    endtask

    // start = cycle stamp of the edge before the one that consumes bit 0.
    task automatic run_frame(input logic mode, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input int gap_a, input int gap_d, input int gap_len, output int start);
        start = cyc;
        for (int i = 0; i < AW; i++) begin
            send_bit(mode, addr[i]);
            if (i == gap_a) idle(gap_len);
        end
        if (mode == MODE_WRITE) begin
            for (int i = 0; i < DW; i++) begin
                send_bit(mode, data[i]);
                if (i == gap_d) idle(gap_len);
            end
        end
        mvalid = 1'b0;
        swdata = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({name, " sready returns"}, {31'd0, sready}, 32'd1);
    endtask

    typedef struct {
        logic          mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            gap_a;
        int            gap_d;
        int            gap_len;
        int            exp_strobe;
        int            exp_rise;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int st, st2, w0, r0, f0;
        logic [AW-1:0] a;

        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, st2, w0, r0, f0;
        logic [AW-1:0] a;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        // mode, addr, data (write data or preloaded read word), gaps, strobe and sready-rise offsets
        vecs[0] = '{1'b1, 12'h0A5, 8'h3C, -1, -1, 0, 20, 21};
        vecs[1] = '{1'b0, 12'h7FF, 8'h96, -1, -1, 0, 12, 22};
        vecs[2] = '{1'b1, 12'h0A5, 8'h3C,  5,  2, 3, 26, 27};
        vecs[3] = '{1'b1, 12'hFFF, 8'h80, -1, -1, 0, 20, 21};
        vecs[4] = '{1'b0, 12'h000, 8'h5A,  0, -1, 4, 16, 26};
        vecs[5] = '{1'b1, 12'h3C3, 8'hE7, -1,  0, 2, 22, 23};

        rst = 1'b1;
        repeat (3) step();
        check("reset sready",    {31'd0, sready},    32'd1);
        check("reset svalid",    {31'd0, svalid},    32'd0);
        check("reset srdata",    {31'd0, srdata},    32'd0);
        check("reset mem_wen",   {31'd0, mem_wen},   32'd0);
        check("reset mem_ren",   {31'd0, mem_ren},   32'd0);
        check("reset mem_addr",  {20'd0, mem_addr},  32'd0);
        check("reset mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].mode == MODE_READ) mem[vecs[i].addr] = vecs[i].data;
            w0 = wen_n; r0 = ren_n; sv_n = 0; rd_word = '0;
            run_frame(vecs[i].mode, vecs[i].addr, vecs[i].data,
                      vecs[i].gap_a, vecs[i].gap_d, vecs[i].gap_len, st);
            wait_idle($sformatf("v%0d", i));
            step();
            check($sformatf("v%0d sready fall", i), fall_cyc - st, 1);
            check($sformatf("v%0d sready rise", i), rise_cyc - st, vecs[i].exp_rise);
            if (vecs[i].mode == MODE_WRITE) begin
                check($sformatf("v%0d wen count", i),  wen_n - w0, 1);
                check($sformatf("v%0d ren count", i),  ren_n - r0, 0);
                check($sformatf("v%0d wen time", i),   wen_cyc - st, vecs[i].exp_strobe);
                check($sformatf("v%0d wen addr", i),   {20'd0, wen_addr}, {20'd0, vecs[i].addr});
                check($sformatf("v%0d wen data", i),   {24'd0, wen_data}, {24'd0, vecs[i].data});
            end else begin
                check($sformatf("v%0d ren count", i),  ren_n - r0, 1);
                check($sformatf("v%0d wen count", i),  wen_n - w0, 0);
                check($sformatf("v%0d ren time", i),   ren_cyc - st, vecs[i].exp_strobe);
                check($sformatf("v%0d ren addr", i),   {20'd0, ren_addr}, {20'd0, vecs[i].addr});
                check($sformatf("v%0d svalid len", i), sv_n, DW);
                check($sformatf("v%0d svalid start", i), sv_first - st, vecs[i].exp_strobe + 2);
                check($sformatf("v%0d read word", i),  {24'd0, rd_word}, {24'd0, vecs[i].data});
            end
        end

        // Back-to-back: write then read the same word, mvalid noise during the read phase.
        w0 = wen_n; r0 = ren_n;
        run_frame(MODE_WRITE, 12'h100, 8'hFF, -1, -1, 0, st);
        wait_idle("b2b write");
        check("b2b wen count", wen_n - w0, 1);
        check("b2b wen addr",  {20'd0, wen_addr}, 32'h100);
        check("b2b wen data",  {24'd0, wen_data}, 32'hFF);
        sv_n = 0; rd_word = '0;
        run_frame(MODE_READ, 12'h100, 8'h00, -1, -1, 0, st2);
        check("b2b read starts on first ready cycle", st2 - wen_cyc, 1);
        smode = 1'b1; swdata = 1'b1; mvalid = 1'b1;
        repeat (9) step();
        mvalid = 1'b0; swdata = 1'b0;
        wait_idle("b2b read");
        step();
        check("b2b ren count",   ren_n - r0, 1);
        check("b2b ren addr",    {20'd0, ren_addr}, 32'h100);
        check("b2b read word",   {24'd0, rd_word}, 32'hFF);
        check("b2b svalid len",  sv_n, DW);
        check("b2b sready rise", rise_cyc - st2, 22);
        idle(5);
        check("b2b no extra wen", wen_n - w0, 1);
        check("b2b no extra ren", ren_n - r0, 1);
        check("b2b still idle",   {31'd0, sready}, 32'd1);

        // Reset after address bit 7 of a write frame.
        w0 = wen_n; r0 = ren_n;
        a = 12'h0A5;
        for (int i = 0; i < 8; i++) send_bit(MODE_WRITE, a[i]);
        rst = 1'b1; mvalid = 1'b0;
        step();
        check("midrst sready",   {31'd0, sready},   32'd1);
        check("midrst svalid",   {31'd0, svalid},   32'd0);
        check("midrst mem_addr", {20'd0, mem_addr}, 32'd0);
        rst = 1'b0;
        idle(3);
        check("midrst no wen", wen_n - w0, 0);
        check("midrst no ren", ren_n - r0, 0);
        mem[12'h001] = 8'h42;
        sv_n = 0; rd_word = '0;
        run_frame(MODE_READ, 12'h001, 8'h00, -1, -1, 0, st);
        wait_idle("midrst read");
        step();
        check("midrst read ren count", ren_n - r0, 1);
        check("midrst read addr", {20'd0, ren_addr}, 32'h001);
        check("midrst read word", {24'd0, rd_word}, 32'h42);

`ifdef SSP_TIMEOUT_EN
        // Stall after address bit 3: the frame is dropped after 16 idle cycles.
        w0 = wen_n; r0 = ren_n; f0 = fe_n;
        a = 12'h0A5;
        st = cyc;
        for (int i = 0; i < 4; i++) send_bit(MODE_WRITE, a[i]);
        idle(25);
        check("timeout frame_err pulses", fe_n - f0, 1);
        check("timeout frame_err time",   fe_cyc - st, 20);
        check("timeout no wen", wen_n - w0, 0);
        check("timeout no ren", ren_n - r0, 0);
        check("timeout sready", {31'd0, sready}, 32'd1);
        mem[12'h2AA] = 8'hC3;
        sv_n = 0; rd_word = '0;
        run_frame(MODE_READ, 12'h2AA, 8'h00, -1, -1, 0, st);
        wait_idle("timeout recover");
        step();
        check("timeout recover ren",  ren_n - r0, 1);
        check("timeout recover word", {24'd0, rd_word}, 32'hC3);
`else
        // Without the gap limit a long stall simply delays the access.
        w0 = wen_n; f0 = fe_n;
        run_frame(MODE_WRITE, 12'h055, 8'h0F, 3, -1, 40, st);
        wait_idle("stall");
        step();
        check("stall wen count", wen_n - w0, 1);
        check("stall wen time",  wen_cyc - st, 60);
        check("stall wen addr",  {20'd0, wen_addr}, 32'h055);
        check("stall wen data",  {24'd0, wen_data}, 32'h0F);
        check("stall no frame_err", fe_n - f0, 0);
`endif

        check("wen/ren never together", ov_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
